// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/issue stage and the ALU.
// Holds the default datapath and instruction widths, the opcode encoding,
// and small opcode-classification helpers used by decode and hazard logic.
package decode_issue_pkg;

    localparam int DEF_ISIZE = 16;
    localparam int DEF_DSIZE = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_XOR  = 4'd3,
        OP_COM  = 4'd4,
        OP_MUL  = 4'd5,
        OP_ADDI = 4'd6,
        OP_LW   = 4'd7,
        OP_SW   = 4'd8,
        OP_BEQ  = 4'd9
    } opcode_e;

    // Opcodes 10..15 are undefined.
    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'd9);
    endfunction

    // Operand B comes from the sign-extended 4-bit immediate.
    function automatic logic op_uses_imm(input logic [3:0] op);
        logic res;
        case (op)
            OP_ADDI, OP_LW, OP_SW: res = 1'b1;
            default:               res = 1'b0;
        endcase
        return res;
    endfunction

    // Second register-file read port carries a real operand
    // (rt for register ops and BEQ, rd for the SW store data).
    function automatic logic op_reads_port2(input logic [3:0] op);
        logic res;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL,
            OP_SW, OP_BEQ: res = 1'b1;
            default:       res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   ex_valid, ex_op, ex_rd : instruction currently held in ID/EX
//   id_op, id_rs, id_rs2   : opcode and read addresses of the instruction in decode
//                            (id_rs2 is the address actually driven on read port 2)
//   hazard                 : decode must wait one cycle for the load result
module hazard_unit
    import decode_issue_pkg::*;
(
    input  logic       ex_valid,
    input  logic [3:0] ex_op,
    input  logic [3:0] ex_rd,
    input  logic [3:0] id_op,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rs2,
    output logic       hazard
);

    // A load writing r0 never creates a dependency; illegal opcodes read nothing.
    always_comb begin
        hazard = 1'b0;
        if (ex_valid && (ex_op == OP_LW) && (ex_rd != 4'd0) && op_legal(id_op)) begin
            if (ex_rd == id_rs) begin
                hazard = 1'b1;
            end else if (op_reads_port2(id_op) && (ex_rd == id_rs2)) begin
                hazard = 1'b1;
            end else begin
                hazard = 1'b0;
            end
        end else begin
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes a fetched instruction, reads the register file
// in the same cycle and loads the ID/EX register one cycle later.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   if_instr, if_valid, if_ready : fetch handshake (accept = if_valid & if_ready)
//   rf_raddr1/2, rf_rdata1/2     : combinational register-file read port pair
//   ex_op, ex_a, ex_b, ex_rd,
//   ex_st_data, ex_valid         : registered ID/EX outputs
//   ex_stall, ex_flush           : back-pressure and branch flush from EX
//   illegal                      : one-cycle pulse after an undefined opcode is accepted
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int ISIZE = DEF_ISIZE,
    parameter int DSIZE = DEF_DSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ISIZE-1:0] if_instr,
    input  logic             if_valid,
    output logic             if_ready,
    output logic [3:0]       rf_raddr1,
    output logic [3:0]       rf_raddr2,
    input  logic [DSIZE-1:0] rf_rdata1,
    input  logic [DSIZE-1:0] rf_rdata2,
    output logic [3:0]       ex_op,
    output logic [DSIZE-1:0] ex_a,
    output logic [DSIZE-1:0] ex_b,
    output logic [3:0]       ex_rd,
    output logic [DSIZE-1:0] ex_st_data,
    output logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_flush,
    output logic             illegal
);

    logic [3:0]       op_s;
    logic [3:0]       rd_s;
    logic [3:0]       rs_s;
    logic [3:0]       rt_s;
    logic             hazard_s;
    logic             accept_s;
    logic             legal_s;
    logic [DSIZE-1:0] imm_ext_s;
    logic [DSIZE-1:0] dec_b_s;
    logic [3:0]       dec_rd_s;
    logic [DSIZE-1:0] dec_st_s;

    assign op_s = if_instr[15:12];
    assign rd_s = if_instr[11:8];
    assign rs_s = if_instr[7:4];
    assign rt_s = if_instr[3:0];

    // SW reuses read port 2 to fetch the store data from the rd register.
    assign rf_raddr1 = rs_s;
    assign rf_raddr2 = (op_s == OP_SW) ? rd_s : rt_s;

    hazard_unit u_hazard (
        .ex_valid (ex_valid),
        .ex_op    (ex_op),
        .ex_rd    (ex_rd),
        .id_op    (op_s),
        .id_rs    (rs_s),
        .id_rs2   (rf_raddr2),
        .hazard   (hazard_s)
    );

    assign if_ready  = !ex_stall && !hazard_s && !ex_flush;
    assign accept_s  = if_valid && if_ready;
    assign legal_s   = op_legal(op_s);
    assign imm_ext_s = {{(DSIZE-4){if_instr[3]}}, if_instr[3:0]};

    // Operand B, destination and store-data selection for the decoded opcode.
    always_comb begin
        dec_b_s  = rf_rdata2;
        dec_rd_s = rd_s;
        dec_st_s = {DSIZE{1'b0}};
        if (op_uses_imm(op_s)) begin
            dec_b_s = imm_ext_s;
        end else begin
            dec_b_s = rf_rdata2;
        end
        case (op_s)
            OP_SW: begin
                dec_rd_s = 4'd0;
                dec_st_s = rf_rdata2;
            end
            OP_BEQ: begin
                dec_rd_s = 4'd0;
                dec_st_s = {DSIZE{1'b0}};
            end
            default: begin
                dec_rd_s = rd_s;
                dec_st_s = {DSIZE{1'b0}};
            end
        endcase
    end

    // ID/EX register: flush beats stall, stall beats bubble insertion.
    // Anything not accepted as a legal instruction becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_op      <= 4'd0;
            ex_a       <= {DSIZE{1'b0}};
            ex_b       <= {DSIZE{1'b0}};
            ex_rd      <= 4'd0;
            ex_st_data <= {DSIZE{1'b0}};
            illegal    <= 1'b0;
        end else if (ex_flush) begin
            ex_valid   <= 1'b0;
            ex_op      <= OP_ADD;
            ex_a       <= {DSIZE{1'b0}};
            ex_b       <= {DSIZE{1'b0}};
            ex_rd      <= 4'd0;
            ex_st_data <= {DSIZE{1'b0}};
            illegal    <= 1'b0;
        end else if (ex_stall) begin
            illegal    <= 1'b0;
        end else if (accept_s && legal_s) begin
            ex_valid   <= 1'b1;
            ex_op      <= op_s;
            ex_a       <= rf_rdata1;
            ex_b       <= dec_b_s;
            ex_rd      <= dec_rd_s;
            ex_st_data <= dec_st_s;
            illegal    <= 1'b0;
        end else begin
            ex_valid   <= 1'b0;
            ex_op      <= OP_ADD;
            ex_a       <= {DSIZE{1'b0}};
            ex_b       <= {DSIZE{1'b0}};
            ex_rd      <= 4'd0;
            ex_st_data <= {DSIZE{1'b0}};
            illegal    <= accept_s;
        end
    end

endmodule
